uart_rx_os: RTL and testbench

- Parametrised oversampling UART receiver with an output FIFO, for the rv_uart_top peripheral path.
- Generalises the fixed 8-bit, 16x, no-parity receive sampler:
  - configurable data width, oversample ratio, parity and stop bits;
  - false-start rejection;
  - per-byte error flags;
  - a show-ahead receive FIFO with overrun detection.
- Clocked by the system clock and advanced by a baud-rate oversample enable pulse.

---
 rtl/uart_rx_os.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, start/data/parity/stop
// sampler with false-start rejection, and a show-ahead receive FIFO with overrun.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          Rst,
    input  logic                          tick,
    input  logic                          rx,
    input  logic                          rd_ready,
    input  logic                          clr_ovr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam logic          PEN       = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rxs_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 push;
    logic [EW-1:0]        push_entry;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        push       = 1'b0;
        push_entry = {shreg_q, ferr_q | ~rxs_q, perr_q};
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == MID_TICK) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        ferr_d     = 1'b0;
                        perr_d     = 1'b0;
                        state_d    = rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        // LSB-first shift: after DATA_BITS samples bit 0 holds the first one
                        shreg_d    = {rxs_q, shreg_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_idx_q == LAST_DATA) begin
                            bit_idx_d = '0;
                            state_d   = PEN ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        perr_d     = ((^shreg_q) ^ rxs_q) != ODD;
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        ferr_d     = ferr_q | ~rxs_q;
                        tick_cnt_d = '0;
                        if (bit_idx_q == LAST_STOP) begin
                            push      = 1'b1;
                            bit_idx_d = '0;
                            state_d   = S_IDLE;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          ovr_q;
    logic          full, do_pop, do_wr, drop;
    logic [EW-1:0] head;

    assign full   = (count_q == (PW+1)'(FIFO_DEPTH));
    assign do_pop = (count_q != '0) & rd_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign do_wr  = push & (~full | do_pop);
    assign drop   = push & full & ~do_pop;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign rd_data       = head[EW-1:2];
    assign rd_frame_err  = head[1];
    assign rd_parity_err = head[0];
    assign rd_valid      = (count_q != '0);
    assign overrun       = ovr_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven bit by bit, a frame-level
// model predicts the received entries, and literal checks pin key results.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       tick = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       rd_ready_a = 1'b0, rd_ready_b = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b;
    logic       ferr_a, ferr_b, perr_a, perr_b;
    logic       ovr_a, ovr_b;
    logic [2:0] cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;

    // Expected entries {data, frame_err, parity_err}, oldest first
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    always #5 clk = ~clk;

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .Rst(Rst), .tick(tick), .rx(rx_a), .rd_ready(rd_ready_a),
        .clr_ovr(clr_ovr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .rd_frame_err(ferr_a), .rd_parity_err(perr_a), .overrun(ovr_a),
        .fifo_count(cnt_a)
    );

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .Rst(Rst), .tick(tick), .rx(rx_b), .rd_ready(rd_ready_b),
        .clr_ovr(clr_ovr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .rd_frame_err(ferr_b), .rd_parity_err(perr_b), .overrun(ovr_b),
        .fifo_count(cnt_b)
    );

    // Whenever a head entry is visible it must match the oldest prediction
    always @(negedge clk) begin
        if (!Rst) begin
            if (rd_valid_a) begin
                vectors++;
                if (qa.size() == 0) begin
                    miscompares++;
                    $display("FAIL headA: got %h, no entry expected", {rd_data_a, ferr_a, perr_a});
                end else begin
                    if ({rd_data_a, ferr_a, perr_a} !== qa[0]) begin
                        miscompares++;
                        $display("FAIL headA: got %h, expected %h", {rd_data_a, ferr_a, perr_a}, qa[0]);
                    end
                    if (rd_ready_a) void'(qa.pop_front());
                end
            end
            if (rd_valid_b) begin
                vectors++;
                if (qb.size() == 0) begin
                    miscompares++;
                    $display("FAIL headB: got %h, no entry expected", {rd_data_b, ferr_b, perr_b});
                end else begin
                    if ({rd_data_b, ferr_b, perr_b} !== qb[0]) begin
                        miscompares++;
                        $display("FAIL headB: got %h, expected %h", {rd_data_b, ferr_b, perr_b}, qb[0]);
                    end
                    if (rd_ready_b) void'(qb.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int inst, input logic v);
        if (inst == 0) rx_a = v;
        else rx_b = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // pbit < 0 means no parity bit on the line; parity instance is odd parity
    task automatic send(input int inst, input logic [7:0] d, input int pbit, input logic stopv);
        logic perr;
        perr = (pbit >= 0) ? ((($countones(d) + pbit) % 2) == 0) : 1'b0;
        if (inst == 0) begin
            if (qa.size() < 4) qa.push_back({d, ~stopv, perr});
        end else begin
            qb.push_back({d, ~stopv, perr});
        end
        drive_bit(inst, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
        if (pbit >= 0) drive_bit(inst, pbit[0]);
        drive_bit(inst, stopv);
    endtask

    task automatic pop(input int inst);
        if (inst == 0) rd_ready_a = 1'b1;
        else rd_ready_b = 1'b1;
        @(posedge clk);
        #1;
        rd_ready_a = 1'b0;
        rd_ready_b = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", rd_valid_a, 0);
        chk("reset_data", rd_data_a, 0);
        chk("reset_count", cnt_a, 0);
        chk("reset_ovr", ovr_a, 0);
        chk("reset_flags", {ferr_a, perr_a}, 0);
        chk("reset_valid_b", rd_valid_b, 0);
        Rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        send(0, 8'hA5, -1, 1'b1);
        chk("a5_valid", rd_valid_a, 1);
        chk("a5_data", rd_data_a, 32'hA5);
        chk("a5_flags", {ferr_a, perr_a}, 0);
        chk("a5_count", cnt_a, 1);
        pop(0);
        chk("a5_pop_valid", rd_valid_a, 0);
        chk("a5_pop_count", cnt_a, 0);

        rx_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_valid", rd_valid_a, 0);
        chk("glitch_count", cnt_a, 0);

        send(0, 8'h3C, -1, 1'b0);
        drive_bit(0, 1'b1);
        chk("ferr_data", rd_data_a, 32'h3C);
        chk("ferr_flag", ferr_a, 1);
        send(0, 8'h5A, -1, 1'b1);
        chk("ferr_count", cnt_a, 2);
        pop(0);
        chk("good_data", rd_data_a, 32'h5A);
        chk("good_ferr", ferr_a, 0);
        pop(0);
        chk("ferr_empty", cnt_a, 0);

        send(1, 8'h07, 0, 1'b1);
        chk("par0_data", rd_data_b, 32'h07);
        chk("par0_perr", perr_b, 0);
        pop(1);
        send(1, 8'h07, 1, 1'b1);
        chk("par1_perr", perr_b, 1);
        chk("par1_ferr", ferr_b, 0);
        pop(1);
        chk("par_empty", rd_valid_b, 0);

        for (int i = 1; i <= 5; i++) send(0, 8'(i), -1, 1'b1);
        chk("ovr_count", cnt_a, 4);
        chk("ovr_flag", ovr_a, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_pop_data", rd_data_a, i);
            pop(0);
        end
        chk("ovr_drained", cnt_a, 0);
        chk("ovr_sticky", ovr_a, 1);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        clr_ovr = 1'b0;
        chk("ovr_cleared", ovr_a, 0);

        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
        rx_a = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        Rst = 1'b1;
        qa.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_count", cnt_a, 0);
        Rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_mid_idle", rd_valid_a, 0);
        send(0, 8'h12, -1, 1'b1);
        chk("rst_data", rd_data_a, 32'h12);
        chk("rst_count", cnt_a, 1);
        chk("rst_flags", {ferr_a, perr_a}, 0);
        pop(0);
        repeat (4) @(posedge clk);
        #1;
        chk("final_count", cnt_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
